dcache_line_evictor: RTL and testbench

//  Writeback/eviction engine on the read side of the dcache data SRAM. Takes an eviction request
//  (set index + tag), reads the full line from the SRAM (1-cycle registered read), captures it,

---
 rtl/dcache_line_evictor.sv | 186 ++++++++++++++++++
 tb/tb_dcache_line_evictor.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_line_evictor.sv
// dcache_line_evictor
//   Writeback engine on the read side of the dcache data SRAM. It accepts an
//   eviction request (set + tag) and reads the line from the SRAM, which has a
//   registered read. It keeps a copy of the line, then sends one address beat
//   followed by BEATS data beats to memory over a valid/ready channel.
//
// Ports
//   clk             single clock, all state on posedge
//   reset           asynchronous, active-low
//   req_valid/ready eviction request handshake (ready only in IDLE)
//   req_set/req_tag set index and tag of the line to evict
//   sram_read_addr  SRAM row address (req_set in IDLE, latched set otherwise)
//   sram_read_data  SRAM row data, valid the cycle after the address is sampled
//   mem_valid/ready memory beat handshake
//   mem_data        address beat or data beat
//   mem_is_addr     current beat is the address beat
//   mem_last        current beat is the final data beat
//   done            one-cycle pulse when the eviction completes
//
// State  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a request; SRAM address follows req_set
// LATCH  | SRAM data for the latched set arrives; captured at cycle end
// ADDR   | address beat presented on the memory channel
// DATA   | data beat cnt_q presented; advances on handshake
// DONE   | one-cycle completion pulse, then back to IDLE

module dcache_line_evictor #(
    parameter int WIDTH        = 512,
    parameter int LOG_NUM_ROWS = 9,
    parameter int WORD_SIZE    = 64,
    parameter int ADDR_BITS    = 64,
    localparam int BEATS       = WIDTH / WORD_SIZE,
    localparam int OFF_BITS    = $clog2(WIDTH / 8),
    localparam int TAG_BITS    = ADDR_BITS - LOG_NUM_ROWS - OFF_BITS,
    localparam int CNT_BITS    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [LOG_NUM_ROWS-1:0] req_set,
    input  logic [TAG_BITS-1:0]     req_tag,
    output logic [LOG_NUM_ROWS-1:0] sram_read_addr,
    input  logic [WIDTH-1:0]        sram_read_data,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic [WORD_SIZE-1:0]    mem_data,
    output logic                    mem_is_addr,
    output logic                    mem_last,
    output logic                    done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_ADDR  = 3'd2,
        S_DATA  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [LOG_NUM_ROWS-1:0]   set_q, set_d;
    logic [TAG_BITS-1:0]       tag_q, tag_d;
    logic [CNT_BITS-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]          line_q;

    logic [WORD_SIZE-1:0]      line_words [BEATS];
    logic [ADDR_BITS-1:0]      line_addr;
    logic                      last_beat;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            set_q   <= '0;
            tag_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
        end
    end

    // The line buffer holds no control meaning, so it is left out of reset.
    // Capturing only in LATCH makes the streamed beats a snapshot that later
    // SRAM writes cannot disturb.
    always_ff @(posedge clk) begin
        if (state_q == S_LATCH) begin
            line_q <= sram_read_data;
        end
    end

    always_comb begin
        for (int b = 0; b < BEATS; b++) begin
            line_words[b] = line_q[b*WORD_SIZE +: WORD_SIZE];
        end
    end

    assign line_addr = {tag_q, set_q, {OFF_BITS{1'b0}}};
    assign last_beat = (cnt_q == CNT_BITS'(BEATS - 1));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    set_d   = req_set;
                    tag_d   = req_tag;
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                state_d = S_ADDR;
            end
            S_ADDR: begin
                if (mem_ready) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (mem_ready) begin
                    if (last_beat) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_BITS'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs, all decoded from registered state. Beat contents depend only
    // on state/counter/buffer, so they stay stable while mem_ready is low.
    // ------------------------------------------------------------------
    always_comb begin
        req_ready      = 1'b0;
        sram_read_addr = set_q;
        mem_valid      = 1'b0;
        mem_is_addr    = 1'b0;
        mem_last       = 1'b0;
        mem_data       = '0;
        done           = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready      = 1'b1;
                sram_read_addr = req_set;
            end
            S_ADDR: begin
                mem_valid   = 1'b1;
                mem_is_addr = 1'b1;
                mem_data    = WORD_SIZE'(line_addr);
            end
            S_DATA: begin
                mem_valid = 1'b1;
                mem_last  = last_beat;
                mem_data  = line_words[cnt_q];
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_line_evictor.sv
// tb_dcache_line_evictor
//   Directed bench for dcache_line_evictor with default parameters
//   (512-bit line, 9-bit set, 64-bit beats, 49-bit tag). The SRAM is
//   modelled with a registered read. Row r word k holds
//   (A5A5_0000_0000_000k) ^ ((r^5) << 32) ^ salt, so row 5 with salt 0
//   gives the plain pattern. The salt can be changed to stand in for
//   SRAM writes.

module tb_dcache_line_evictor;

    logic         clk;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [8:0]   req_set;
    logic [48:0]  req_tag;
    logic [8:0]   sram_read_addr;
    logic [511:0] sram_read_data;
    logic         mem_valid;
    logic         mem_ready;
    logic [63:0]  mem_data;
    logic         mem_is_addr;
    logic         mem_last;
    logic         done;

    logic [63:0]  sram_salt;
    int           checks;
    int           errors;
    int           n_addr_hs;
    int           n_data_hs;
    int           n_done;

    dcache_line_evictor dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_set        (req_set),
        .req_tag        (req_tag),
        .sram_read_addr (sram_read_addr),
        .sram_read_data (sram_read_data),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_data       (mem_data),
        .mem_is_addr    (mem_is_addr),
        .mem_last       (mem_last),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] word_of(input logic [8:0] r, input int k,
                                            input logic [63:0] salt);
        return (64'hA5A5_0000_0000_0000 | 64'(k)) ^ {23'b0, r ^ 9'd5, 32'b0} ^ salt;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            sram_read_data[k*64 +: 64] <= word_of(sram_read_addr, k, sram_salt);
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            if (mem_valid && mem_ready && mem_is_addr)  n_addr_hs <= n_addr_hs + 1;
            if (mem_valid && mem_ready && !mem_is_addr) n_data_hs <= n_data_hs + 1;
            if (done) n_done <= n_done + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete eviction starting from IDLE. Optionally stalls one data
    // beat, keeps req_valid high with a new set for a back-to-back request,
    // or changes SRAM contents once the line has been captured.
    task automatic evict(input logic [8:0] set, input logic [48:0] tag,
                         input logic [63:0] exp_addr, input int stall_beat,
                         input int stall_n, input bit hold_next,
                         input logic [8:0] next_set, input bit scramble);
        logic [63:0] exp_salt;
        int a0, d0, n0;
        exp_salt = sram_salt;
        a0 = n_addr_hs;
        d0 = n_data_hs;
        n0 = n_done;
        req_set   = set;
        req_tag   = tag;
        req_valid = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("idle_req_ready", req_ready, 1);
        chk("idle_sram_addr", sram_read_addr, set);
        step();
        if (hold_next) req_set = next_set;
        else req_valid = 1'b0;
        #1;
        chk("latch_req_ready", req_ready, 0);
        chk("latch_mem_valid", mem_valid, 0);
        chk("latch_sram_addr", sram_read_addr, set);
        step();
        if (scramble) sram_salt = 64'h0F0F_1234_5678_9ABC;
        chk("addr_valid", mem_valid, 1);
        chk("addr_is_addr", mem_is_addr, 1);
        chk("addr_data", mem_data, exp_addr);
        chk("addr_last", mem_last, 0);
        chk("addr_req_ready", req_ready, 0);
        step();
        for (int k = 0; k < 8; k++) begin
            if (k == stall_beat) begin
                mem_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    chk("stall_valid", mem_valid, 1);
                    chk("stall_data", mem_data, word_of(set, k, exp_salt));
                    chk("stall_last", mem_last, (k == 7));
                    step();
                end
                mem_ready = 1'b1;
            end
            chk("data_valid", mem_valid, 1);
            chk("data_is_addr", mem_is_addr, 0);
            chk("data_word", mem_data, word_of(set, k, exp_salt));
            chk("data_last", mem_last, (k == 7));
            chk("data_sram_addr", sram_read_addr, set);
            chk("data_req_ready", req_ready, 0);
            step();
        end
        chk("done_pulse", done, 1);
        chk("done_mem_valid", mem_valid, 0);
        chk("done_req_ready", req_ready, 0);
        step();
        chk("post_done", done, 0);
        chk("post_req_ready", req_ready, 1);
        chk("addr_handshakes", 64'(n_addr_hs - a0), 1);
        chk("data_handshakes", 64'(n_data_hs - d0), 8);
        chk("done_count", 64'(n_done - n0), 1);
    endtask

    initial begin
        int n0;
        checks    = 0;
        errors    = 0;
        n_addr_hs = 0;
        n_data_hs = 0;
        n_done    = 0;
        sram_salt = '0;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_set   = '0;
        req_tag   = '0;
        mem_ready = 1'b0;

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'($urandom);
            req_set   = 9'($urandom);
            req_tag   = {17'($urandom), 32'($urandom)};
            mem_ready = 1'($urandom);
            step();
            chk("rst_mem_valid", mem_valid, 0);
            chk("rst_done", done, 0);
            chk("rst_req_ready", req_ready, 1);
            chk("rst_mem_data", mem_data, 0);
            chk("rst_is_addr", mem_is_addr, 0);
            chk("rst_last", mem_last, 0);
        end
        req_valid = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        step();

        // Single eviction, memory always ready
        evict(9'd5, 49'h1234, 64'h0000_0000_091A_0140, -1, 0, 1'b0, 9'd0, 1'b0);

        // Backpressure on data beat 3 for three cycles
        evict(9'd5, 49'h1234, 64'h0000_0000_091A_0140, 3, 3, 1'b0, 9'd0, 1'b0);

        // Back-to-back: second request held during the first transfer
        evict(9'd5, 49'h1234, 64'h0000_0000_091A_0140, -1, 0, 1'b1, 9'd6, 1'b0);
        evict(9'd6, 49'h0ABC, 64'h0000_0000_055E_0180, -1, 0, 1'b0, 9'd0, 1'b0);

        // Reset in the middle of data beat 4
        n0 = n_done;
        req_set   = 9'd5;
        req_tag   = 49'h1234;
        req_valid = 1'b1;
        mem_ready = 1'b1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("abort_beat4", mem_data, word_of(9'd5, 4, sram_salt));
        #3;
        reset = 1'b0;
        #1;
        chk("abort_mem_valid", mem_valid, 0);
        chk("abort_mem_data", mem_data, 0);
        chk("abort_req_ready", req_ready, 1);
        chk("abort_done", done, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("abort_no_done", 64'(n_done - n0), 0);
        chk("abort_idle_valid", mem_valid, 0);
        evict(9'd5, 49'h1234, 64'h0000_0000_091A_0140, -1, 0, 1'b0, 9'd0, 1'b0);

        // Boundary: highest set, all-ones tag
        evict(9'd511, {49{1'b1}}, 64'hFFFF_FFFF_FFFF_FFC0, 7, 2, 1'b0, 9'd0, 1'b0);

        // SRAM contents change after capture; beats must be the snapshot
        evict(9'd5, 49'h1234, 64'h0000_0000_091A_0140, 0, 1, 1'b0, 9'd0, 1'b1);
        // New contents are visible to the next eviction
        evict(9'd5, 49'h1234, 64'h0000_0000_091A_0140, -1, 0, 1'b0, 9'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
